// File: rtl/x3q_fetch_queue.sv
// Instruction prefetch queue for the x3q core: issues sequential single-outstanding
// reads, buffers returned words, and hands them to decode; redirect flushes and restarts.
module x3q_fetch_queue #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_STEP  = 1,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            memory_in,
  input  logic                         memory_ready,
  input  logic                         hold,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_addr,
  input  logic                         instr_ready,
  output logic                         request,
  output logic                         request_type,
  output logic [ADDR_W-1:0]            request_address,
  output logic                         instr_valid,
  output logic [DATA_W-1:0]            instr_data,
  output logic [ADDR_W-1:0]            instr_addr,
  output logic [$clog2(DEPTH+1)-1:0]   queue_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [LVL_W-1:0]  level;
  logic              issue;
  logic              push;
  logic              pop;

  // Redirect overrides issue, push and pop in the same cycle.
  assign issue = (state == IDLE) && !hold && (level < LVL_W'(DEPTH)) && !redirect_valid;
  assign push  = (state == WAIT) && memory_ready && !redirect_valid;
  assign pop   = (level != '0) && instr_ready && !redirect_valid;

  assign request_type = 1'b0;
  assign instr_valid  = (level != '0);
  assign instr_data   = data_q[rd_ptr];
  assign instr_addr   = addr_q[rd_ptr];
  assign queue_level  = level;

  // Fetch sequencing: one outstanding read; stale responses after redirect are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      fetch_addr      <= ADDR_W'(RESET_ADDR);
      request         <= 1'b0;
      request_address <= ADDR_W'(RESET_ADDR);
    end else begin
      request <= issue;
      if (issue) request_address <= fetch_addr;

      if (redirect_valid)  fetch_addr <= redirect_addr;
      else if (push)       fetch_addr <= fetch_addr + ADDR_W'(ADDR_STEP);

      case (state)
        IDLE:    if (issue) state <= WAIT;
        WAIT: begin
          if (memory_ready)        state <= IDLE;
          else if (redirect_valid) state <= DISCARD;
        end
        DISCARD: if (memory_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Circular buffer; a slot is reserved at issue so a push never overflows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= memory_in;
        addr_q[wr_ptr] <= request_address;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule
